ofm_writeback: RTL

Write-back engine on the output side of the MB-CONV sub-top. It captures the 16 per-lane OFM bytes from the PE cluster whenever all lanes report valid, and buffers them in a 2-entry vector buffer. It packs each vector into four 32-bit words and drives them as sequential word writes into an OFM BRAM, starting at a programmed base address. It is the writer counterpart of the BRAM load path that feeds IFM and weights into the cluster.

---
 rtl/ofm_writeback.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ofm_writeback.sv
`default_nettype none
// ============================================================================
// ofm_writeback : buffers 16-lane OFM vectors and writes them to BRAM as 32-bit words
// Revision      : 1.0
// ============================================================================
module ofm_writeback #(
  parameter int BUF_DEPTH = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_vectors,
  input  logic [15:0]       valid,
  input  logic [7:0]        OFM_0,
  input  logic [7:0]        OFM_1,
  input  logic [7:0]        OFM_2,
  input  logic [7:0]        OFM_3,
  input  logic [7:0]        OFM_4,
  input  logic [7:0]        OFM_5,
  input  logic [7:0]        OFM_6,
  input  logic [7:0]        OFM_7,
  input  logic [7:0]        OFM_8,
  input  logic [7:0]        OFM_9,
  input  logic [7:0]        OFM_10,
  input  logic [7:0]        OFM_11,
  input  logic [7:0]        OFM_12,
  input  logic [7:0]        OFM_13,
  input  logic [7:0]        OFM_14,
  input  logic [7:0]        OFM_15,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              lane_err
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [15:0]        num_q, num_d;
  logic [15:0]        vec_cnt_q, vec_cnt_d;
  logic [1:0]         beat_q, beat_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [127:0]       buf_q [BUF_DEPTH];
  logic [127:0]       buf_d [BUF_DEPTH];
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic               lane_err_q, lane_err_d;

  logic [127:0]       lane_vec;
  logic [127:0]       head;
  logic               push, pop, push_ok, full;

  // Lane 0 sits in the low byte so word k naturally carries lanes 4k..4k+3.
  assign lane_vec = {OFM_15, OFM_14, OFM_13, OFM_12, OFM_11, OFM_10, OFM_9, OFM_8,
                     OFM_7,  OFM_6,  OFM_5,  OFM_4,  OFM_3,  OFM_2,  OFM_1, OFM_0};
  assign head     = buf_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(BUF_DEPTH));

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    vec_cnt_d  = vec_cnt_q;
    beat_d     = beat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    buf_d      = buf_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    lane_err_d = lane_err_q;
    push       = 1'b0;
    pop        = 1'b0;
    push_ok    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          base_d     = base_addr;
          num_d      = num_vectors;
          vec_cnt_d  = '0;
          beat_d     = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          lane_err_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      RUN: begin
        if (vec_cnt_q == num_q) begin
          // Anything still buffered past the requested count is dropped here.
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          if (valid == 16'hFFFF) begin
            push = 1'b1;
          end else if (valid != 16'h0000) begin
            lane_err_d = 1'b1;
          end

          if (count_q != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + ADDR_W'({vec_cnt_q, beat_q});
            wr_data_d = head[{beat_q, 5'd0} +: 32];
            beat_d    = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              pop       = 1'b1;
              vec_cnt_d = vec_cnt_q + 16'd1;
              rd_ptr_d  = ptr_inc(rd_ptr_q);
            end
          end

          // A pop in the same cycle frees the slot, so full+pop still accepts.
          if (push) begin
            if (full && !pop) begin
              overflow_d = 1'b1;
            end else begin
              push_ok          = 1'b1;
              buf_d[wr_ptr_q]  = lane_vec;
              wr_ptr_d         = ptr_inc(wr_ptr_q);
            end
          end

          if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
          end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      vec_cnt_q  <= '0;
      beat_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      lane_err_q <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      vec_cnt_q  <= vec_cnt_d;
      beat_q     <= beat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      lane_err_q <= lane_err_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign lane_err = lane_err_q;

endmodule
`default_nettype wire
